mac_feeder: RTL
===============

# mac_feeder

Sequencer that sits directly upstream of the 3-tap signed MAC in the convolution datapath. It loads three weights and a stream of `len` features from two synchronous-read memories into the MAC's shift registers. It registers every valid MAC output as a 1-D convolution result. In steady state it produces one result per clock.

## Interface
Parameters:
- `DATA_BIT`, 16: operand width; the result is `2*DATA_BIT+2` bits.
- `ADDR_W`, 8: memory address width; also the width of `len` and `res_idx`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: job request; sampled only in IDLE.
- `len`, in, ADDR_W: feature count N; sampled with `start`; valid range 3..2^ADDR_W-1.
- `w_rd`, out, 1: weight memory read enable.
- `w_addr`, out, ADDR_W: weight address.
- `w_rdata`, in, DATA_BIT: weight data, valid the cycle after `w_rd`.
- `f_rd`, out, 1: feature memory read enable.
- `f_addr`, out, ADDR_W: feature address.
- `f_rdata`, in, DATA_BIT: feature data, valid the cycle after `f_rd`.
- `mac_clear`, out, 1: MAC clear.
- `mac_w_w`, out, 1: MAC weight write.
- `mac_w_in`, out, DATA_BIT: MAC weight data.
- `mac_if_w`, out, 1: MAC feature write.
- `mac_if_in`, out, DATA_BIT: MAC feature data.
- `mac_out`, in, 2*DATA_BIT+2: combinational MAC sum, signed.
- `res_valid`, out, 1: result strobe, one cycle per result.
- `res_data`, out, 2*DATA_BIT+2: registered result, signed.
- `res_idx`, out, ADDR_W: result index k, 0..N-3.
- `busy`, out, 1: job in progress.
- `done`, out, 1: one-cycle end-of-job pulse.

## Operation
- FSM states and transitions:
  - IDLE -> CLR on `start` with `len`>=3.
  - CLR (1 cycle) -> LDW.
  - LDW (3 cycles) -> LDF.
  - LDF (N cycles) -> FLUSH.
  - FLUSH (3 cycles) -> DONE.
  - DONE (1 cycle) -> IDLE.
- `start` with `len`<3 is ignored: no reads, no `done`. `start` outside IDLE is ignored.
- CLR: `mac_clear`=1 for exactly one cycle. `mac_clear` is never asserted together with `mac_w_w` or `mac_if_w`.
- LDW: `w_rd`=1 with `w_addr`=0,1,2 on consecutive cycles.
- Weight write: `mac_w_w` is `w_rd` delayed by one cycle, and `mac_w_in`=`w_rdata`. Weight 0 therefore ends up in the MAC's oldest tap.
- LDF: `f_rd`=1 with `f_addr`=0..N-1 on consecutive cycles.
- Feature write: `mac_if_w` is `f_rd` delayed by one cycle, and `mac_if_in`=`f_rdata`.
- Feature counter: the block counts features written into the MAC. After the edge that writes feature k (k>=2), `mac_out` is valid for the whole next cycle. At the end of that cycle the block captures `res_data`<=`mac_out` and `res_idx`<=k-2, and asserts `res_valid` for the following cycle.
- Result definition: res[k] = w0·f[k] + w1·f[k+1] + w2·f[k+2], two's complement, no saturation. The 34-bit width cannot overflow.
- Results per job: exactly N-2, in strictly increasing `res_idx` order, with no gaps.
- Idle output values: all read enables and MAC strobes are 0 outside their states. Addresses and data hold their last value; they carry no meaning when strobes are low.
- `res_data` and `res_idx` hold their value between strobes.

## Timing
Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- Cycle 1: `mac_clear`.
- Cycles 2-4: `w_rd`.
- Cycles 3-5: `mac_w_w`.
- Cycles 5..4+N: `f_rd`.
- Cycles 6..5+N: `mac_if_w`.
- Cycles 10..7+N: `res_valid`.
- Cycle 8+N: `done`=1 and `busy`=0.
- `busy`=1 in cycles 1..7+N.
- The earliest accepted next `start` is in cycle 9+N.
- Latency from `f_rd` of address k+2 to `res_valid` of result k is 3 cycles.
- Reset values: state IDLE; every output 0, including `res_data`, `res_idx`, both addresses and the MAC data outputs.
- Reset mid-job: outputs go to their reset values immediately and asynchronously. No further reads or strobes occur, and no `done` is issued. The MAC shares `rst`.

## Test plan
- Basic job: weights 1,2,3; features 1,2,3,4,5; N=5; `start` at cycle 0 -> `res_valid` in cycles 10,11,12 with `res_data`=14,20,26 and `res_idx`=0,1,2; `done` in cycle 13.
- Minimum length: N=3, weights 1,1,1, features 4,5,6 -> a single result of 15 in cycle 10; `done` in cycle 11.
- Signed extremes: all weights and features 0x8000 -> result +3221225472. Mixed case: weights 0xFFFF,0x0002,0x0000; features 5,7,9 -> result 9.
- Rejected starts: `start` with N=2 -> no reads and no `done`. `start` pulsed during LDF -> ignored, current job completes unchanged.
- Reset mid-LDF: assert `rst` in cycle 7 -> all outputs 0 immediately. A new job after reset release gives results identical to a fresh job.
- Back-to-back jobs: second `start` in cycle 9+N with different weights -> MAC cleared first, and no stale weights or features appear in the second job's results.

Source files
------------

// File: rtl/mac_feeder.sv
// Sequencer feeding a 3-tap signed MAC: clears it, loads three weights and N
// features from synchronous-read memories, and registers each valid MAC sum.
module mac_feeder #(
  parameter int DATA_BIT = 16,
  parameter int ADDR_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         len,
  output logic                      w_rd,
  output logic [ADDR_W-1:0]         w_addr,
  input  logic [DATA_BIT-1:0]       w_rdata,
  output logic                      f_rd,
  output logic [ADDR_W-1:0]         f_addr,
  input  logic [DATA_BIT-1:0]       f_rdata,
  output logic                      mac_clear,
  output logic                      mac_w_w,
  output logic [DATA_BIT-1:0]       mac_w_in,
  output logic                      mac_if_w,
  output logic [DATA_BIT-1:0]       mac_if_in,
  input  logic [2*DATA_BIT+1:0]     mac_out,
  output logic                      res_valid,
  output logic [2*DATA_BIT+1:0]     res_data,
  output logic [ADDR_W-1:0]         res_idx,
  output logic                      busy,
  output logic                      done
);

  localparam logic [ADDR_W-1:0] MIN_LEN = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] LAST_W  = ADDR_W'(2);

  typedef enum logic [2:0] {IDLE, CLR, LDW, LDF, FLUSH, DONE} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   len_r;
  logic [ADDR_W-1:0]   fw_cnt;
  logic [ADDR_W-1:0]   cap_idx;
  logic                cap;
  logic [1:0]          fl_cnt;
  logic [DATA_BIT-1:0] w_hold, f_hold;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && (len >= MIN_LEN)) state_nx = CLR;
      CLR:     state_nx = LDW;
      LDW:     if (w_addr == LAST_W) state_nx = LDF;
      LDF:     if (f_addr == len_r - ADDR_W'(1)) state_nx = FLUSH;
      FLUSH:   if (fl_cnt == 2'd2) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign mac_clear = (state == CLR);
  assign w_rd      = (state == LDW);
  assign f_rd      = (state == LDF);
  assign done      = (state == DONE);
  assign busy      = (state == CLR) || (state == LDW) || (state == LDF) || (state == FLUSH);

  // Memory data passes straight through on the write cycle; the hold register
  // keeps the last value on the port otherwise and gives a clean reset value.
  assign mac_w_in  = mac_w_w  ? w_rdata : w_hold;
  assign mac_if_in = mac_if_w ? f_rdata : f_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_r     <= '0;
      w_addr    <= '0;
      f_addr    <= '0;
      fw_cnt    <= '0;
      fl_cnt    <= '0;
      mac_w_w   <= 1'b0;
      mac_if_w  <= 1'b0;
      w_hold    <= '0;
      f_hold    <= '0;
      cap       <= 1'b0;
      cap_idx   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start && (len >= MIN_LEN)) len_r <= len;

      mac_w_w  <= w_rd;
      mac_if_w <= f_rd;
      if (mac_w_w)  w_hold <= w_rdata;
      if (mac_if_w) begin
        f_hold <= f_rdata;
        fw_cnt <= fw_cnt + ADDR_W'(1);
      end

      case (state)
        CLR: begin
          w_addr <= '0;
          f_addr <= '0;
          fw_cnt <= '0;
          fl_cnt <= '0;
        end
        LDW:   if (w_addr != LAST_W) w_addr <= w_addr + ADDR_W'(1);
        LDF:   if (f_addr != len_r - ADDR_W'(1)) f_addr <= f_addr + ADDR_W'(1);
        FLUSH: fl_cnt <= fl_cnt + 2'd1;
        default: ;
      endcase

      // Writing feature k>=2 makes mac_out valid next cycle; capture at its end.
      cap     <= mac_if_w && (fw_cnt >= LAST_W);
      cap_idx <= fw_cnt - LAST_W;

      res_valid <= cap;
      if (cap) begin
        res_data <= mac_out;
        res_idx  <= cap_idx;
      end
    end
  end

endmodule
